// File: rtl/alloc_inst_check_stage.sv
`default_nettype none
// ============================================================================
// Module   : alloc_inst_check_stage
// Brief    : Registered allocation-stage instruction checker with a budget for
//            in-flight speculative branches. Optional ALLOC_CHK_PERF_CNT_EN
//            adds stall and accept performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module alloc_inst_check_stage #(
    parameter int LANES       = 4,
    parameter int INST_W      = 66,
    parameter int PC_W        = 16,
    parameter int SPEC_BR_MAX = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*INST_W-1:0] inst_in,
    input  logic [7:0]              brch_resolve_cnt,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES-1:0]        pr_need_to_rob,
    output logic [LANES*PC_W-1:0]   rcvr_pc_to_rob,
    output logic [LANES-1:0]        str_en_to_rob,
    output logic [2*LANES-1:0]      brch_mode_to_rob,
    output logic [LANES-1:0]        brch_pred_res_to_rob,
    output logic [LANES-1:0]        spec_brch_to_rob,
    output logic [LANES-1:0]        jr_to_rob,
    output logic [LANES-1:0]        no_exe_to_rob,
    output logic [LANES-1:0]        inst_val_to_rob,
    output logic [7:0]              spec_br_inflight
`ifdef ALLOC_CHK_PERF_CNT_EN
    ,
    output logic [31:0]             perf_stall_br,
    output logic [31:0]             perf_grp_acc
`endif
);

    localparam int GS_W  = $clog2(LANES + 1);
    localparam int SUM_W = 16;

    logic [PC_W-1:0]  w_pc     [LANES];
    logic [1:0]       w_mode   [LANES];
    logic [LANES-1:0] w_val;
    logic [LANES-1:0] w_bit16;
    logic [LANES-1:0] w_str;
    logic [LANES-1:0] w_spec;
    logic [LANES-1:0] w_jr;
    logic [LANES-1:0] w_no_exe;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic [INST_W-1:0] w_word;
            logic              w_unused_bits;
            assign w_word        = inst_in[i*INST_W +: INST_W];
            assign w_unused_bits = ^w_word;
            assign w_pc[i]       = w_word[PC_W-1:0];
            assign w_mode[i]     = w_word[31:30];
            assign w_val[i]      = w_word[65];
            assign w_bit16[i]    = w_word[16];
            assign w_str[i]      = w_word[25];
            // Modes 01 (cond) and 11 (jr) both rely on prediction.
            assign w_spec[i]     = w_word[65] & w_word[30];
            assign w_jr[i]       = w_word[65] & (w_word[31:30] == 2'b11);
            assign w_no_exe[i]   = w_word[65] & (w_word[31:30] == 2'b10);
        end
    endgenerate

    logic [GS_W-1:0]  w_grp_spec;
    logic [7:0]       w_resolved;
    logic [7:0]       w_avail;
    logic             w_budget_ok;
    logic             w_slot_free;
    logic             w_accept;
    logic             r_out_valid;
    logic [7:0]       r_inflight;

    always_comb begin
        w_grp_spec = '0;
        for (int i = 0; i < LANES; i++) begin
            w_grp_spec = w_grp_spec + GS_W'(w_spec[i]);
        end
    end

    assign w_resolved  = (brch_resolve_cnt > r_inflight) ? r_inflight : brch_resolve_cnt;
    assign w_avail     = r_inflight - w_resolved;
    assign w_budget_ok = (SUM_W'(w_avail) + SUM_W'(w_grp_spec)) <= SUM_W'(SPEC_BR_MAX);
    assign w_slot_free = !r_out_valid || out_ready;
    assign in_ready    = !flush && w_slot_free && w_budget_ok;
    assign w_accept    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_inflight  <= 8'd0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_inflight  <= 8'd0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            r_inflight <= w_avail + (w_accept ? 8'(w_grp_spec) : 8'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pr_need_to_rob       <= '0;
            rcvr_pc_to_rob       <= '0;
            str_en_to_rob        <= '0;
            brch_mode_to_rob     <= '0;
            brch_pred_res_to_rob <= '0;
            spec_brch_to_rob     <= '0;
            jr_to_rob            <= '0;
            no_exe_to_rob        <= '0;
            inst_val_to_rob      <= '0;
        end else if (w_accept) begin
            pr_need_to_rob       <= w_bit16;
            str_en_to_rob        <= w_str;
            brch_pred_res_to_rob <= w_bit16;
            spec_brch_to_rob     <= w_spec;
            jr_to_rob            <= w_jr;
            no_exe_to_rob        <= w_no_exe;
            inst_val_to_rob      <= w_val;
            for (int i = 0; i < LANES; i++) begin
                rcvr_pc_to_rob[i*PC_W +: PC_W] <= w_pc[i];
                brch_mode_to_rob[2*i +: 2]     <= w_mode[i];
            end
        end
    end

    assign out_valid        = r_out_valid;
    assign spec_br_inflight = r_inflight;

`ifdef ALLOC_CHK_PERF_CNT_EN
    logic        w_stall;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_acc;

    // Only budget-caused stalls count; a busy output slot is not a branch stall.
    assign w_stall = in_valid && !flush && w_slot_free && !w_budget_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall <= 32'd0;
            r_perf_acc   <= 32'd0;
        end else begin
            if (w_stall) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_accept) begin
                r_perf_acc <= r_perf_acc + 32'd1;
            end
        end
    end

    assign perf_stall_br = r_perf_stall;
    assign perf_grp_acc  = r_perf_acc;
`endif

endmodule
`default_nettype wire
